// File: rtl/uart_pkg.sv
// Shared UART types and constants for the byte FIFO and its neighbours.
package uart_pkg;

   typedef logic [7:0] uart_byte_t;

   localparam int UART_FIFO_DEPTH_LOG2 = 4;
   localparam int UART_OVF_CNT_W       = 8;

endpackage

// File: rtl/uart_byte_fifo_ram.sv
// Byte storage for uart_byte_fifo: one synchronous write port and one
// asynchronous read port. Contents are never reset.
module uart_byte_fifo_ram
   import uart_pkg::*;
#(
   parameter int ADDR_W = UART_FIFO_DEPTH_LOG2
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  uart_byte_t        wdata,
   input  logic [ADDR_W-1:0] raddr,
   output uart_byte_t        rdata
);

   uart_byte_t mem [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/uart_byte_fifo.sv
// Show-ahead byte FIFO between uart_rx and uart_tx with registered almost_full.
// Defining UART_BYTE_FIFO_STATS_EN adds the saturating overflow_cnt output.
module uart_byte_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH_LOG2 = UART_FIFO_DEPTH_LOG2,
   parameter int AF_LEVEL   = 12
) (
   input  logic       clk,
   input  logic       reset_,
   input  logic       wr_req,
   output logic       wr_ready,
   input  uart_byte_t wr_data,
   output logic       rd_req,
   input  logic       rd_ready,
   output uart_byte_t rd_data,
   output logic       almost_full
`ifdef UART_BYTE_FIFO_STATS_EN
   ,
   output logic [UART_OVF_CNT_W-1:0] overflow_cnt
`endif
);

   localparam logic [DEPTH_LOG2:0] PTR_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};
   localparam logic [DEPTH_LOG2:0] AF_LVL  = AF_LEVEL[DEPTH_LOG2:0];

   logic [DEPTH_LOG2:0] wr_ptr, rd_ptr, count, count_nxt;
   logic                empty, full, wr_en, rd_en;

   // Extra MSB on the pointers separates full from empty when the indices match.
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                  (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);

   assign wr_ready = !full;
   assign rd_req   = !empty;
   assign wr_en    = reset_ && wr_req && !full;
   assign rd_en    = rd_ready && !empty;

   always_comb begin
      count_nxt = count;
      case ({wr_en, rd_en})
         2'b10:   count_nxt = count + PTR_ONE;
         2'b01:   count_nxt = count - PTR_ONE;
         default: count_nxt = count;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         almost_full <= 1'b0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
         if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
         count       <= count_nxt;
         almost_full <= (count_nxt >= AF_LVL);
      end
   end

   uart_byte_fifo_ram #(
      .ADDR_W (DEPTH_LOG2)
   ) u_ram (
      .clk   (clk),
      .we    (wr_en),
      .waddr (wr_ptr[DEPTH_LOG2-1:0]),
      .wdata (wr_data),
      .raddr (rd_ptr[DEPTH_LOG2-1:0]),
      .rdata (rd_data)
   );

`ifdef UART_BYTE_FIFO_STATS_EN
   localparam logic [UART_OVF_CNT_W-1:0] OVF_ONE = {{(UART_OVF_CNT_W-1){1'b0}}, 1'b1};

   always_ff @(posedge clk) begin
      if (!reset_)
         overflow_cnt <= '0;
      else if (wr_req && full && (overflow_cnt != '1))
         overflow_cnt <= overflow_cnt + OVF_ONE;
   end
`endif

endmodule

// File: tb/tb_uart_byte_fifo.sv
// Self-checking bench for uart_byte_fifo against a queue-based reference model.
module tb_uart_byte_fifo;

   localparam int CAP = 16;
   localparam int AF  = 12;

   logic       clk = 1'b0;
   logic       reset_;
   logic       wr_req;
   logic       wr_ready;
   logic [7:0] wr_data;
   logic       rd_req;
   logic       rd_ready;
   logic [7:0] rd_data;
   logic       almost_full;
`ifdef UART_BYTE_FIFO_STATS_EN
   logic [7:0] overflow_cnt;
`endif

   int         total = 0;
   int         bad   = 0;
   int         ovf_m = 0;
   logic [7:0] q [$];

   always #5 clk = ~clk;

   uart_byte_fifo dut (
      .clk          (clk),
      .reset_       (reset_),
      .wr_req       (wr_req),
      .wr_ready     (wr_ready),
      .wr_data      (wr_data),
      .rd_req       (rd_req),
      .rd_ready     (rd_ready),
      .rd_data      (rd_data),
      .almost_full  (almost_full)
`ifdef UART_BYTE_FIFO_STATS_EN
      ,
      .overflow_cnt (overflow_cnt)
`endif
   );

   // Apply one cycle of stimulus, advance the model across the edge, settle 1 time unit.
   task automatic drive(input logic rst, input logic wr, input logic [7:0] d, input logic rd);
      bit m_full;
      bit m_empty;
      reset_   = rst;
      wr_req   = wr;
      wr_data  = d;
      rd_ready = rd;
      m_full   = (q.size() == CAP);
      m_empty  = (q.size() == 0);
      @(posedge clk);
      if (!rst) begin
         q.delete();
         ovf_m = 0;
      end else begin
         if (wr && m_full && ovf_m < 255) ovf_m++;
         if (rd && !m_empty) void'(q.pop_front());
         if (wr && !m_full) q.push_back(d);
      end
      #1;
   endtask

   task automatic test_reset();
      drive(1'b0, 1'b0, 8'h00, 1'b0);
      drive(1'b0, 1'b0, 8'h00, 1'b0);
      total++; if (rd_req !== 1'b0) begin bad++; $display("FAIL reset_rd_req got=%0b exp=0", rd_req); end
      total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL reset_wr_ready got=%0b exp=1", wr_ready); end
      total++; if (almost_full !== 1'b0) begin bad++; $display("FAIL reset_af got=%0b exp=0", almost_full); end
   endtask

   task automatic test_show_ahead();
      logic [7:0] bytes [3];
      bytes[0] = 8'h41; bytes[1] = 8'h42; bytes[2] = 8'h43;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b1, bytes[i], 1'b0);
         total++; if (rd_req !== 1'b1) begin bad++; $display("FAIL show_rd_req[%0d] got=%0b exp=1", i, rd_req); end
         total++; if (rd_data !== 8'h41) begin bad++; $display("FAIL show_rd_data[%0d] got=%h exp=41", i, rd_data); end
      end
      while (q.size() != 0) begin
         total++; if (rd_data !== q[0]) begin bad++; $display("FAIL show_drain got=%h exp=%h", rd_data, q[0]); end
         drive(1'b1, 1'b0, 8'h00, 1'b1);
      end
      total++; if (rd_req !== 1'b0) begin bad++; $display("FAIL show_empty got=%0b exp=0", rd_req); end
   endtask

   task automatic test_fill();
      for (int i = 0; i < CAP; i++) begin
         drive(1'b1, 1'b1, 8'(i), 1'b0);
         total++; if (almost_full !== (i >= AF - 1)) begin bad++; $display("FAIL fill_af[%0d] got=%0b exp=%0b", i, almost_full, (i >= AF - 1)); end
         total++; if (wr_ready !== (i < CAP - 1)) begin bad++; $display("FAIL fill_wr_ready[%0d] got=%0b exp=%0b", i, wr_ready, (i < CAP - 1)); end
      end
      drive(1'b1, 1'b1, 8'hFF, 1'b0);
      total++; if (wr_ready !== 1'b0) begin bad++; $display("FAIL drop_wr_ready got=%0b exp=0", wr_ready); end
      total++; if (rd_data !== 8'h00) begin bad++; $display("FAIL drop_head got=%h exp=00", rd_data); end
      for (int i = 0; i < CAP; i++) begin
         total++; if (rd_req !== 1'b1) begin bad++; $display("FAIL fill_read_req[%0d] got=%0b exp=1", i, rd_req); end
         total++; if (rd_data !== 8'(i)) begin bad++; $display("FAIL fill_read[%0d] got=%h exp=%h", i, rd_data, 8'(i)); end
         drive(1'b1, 1'b0, 8'h00, 1'b1);
      end
      total++; if (rd_req !== 1'b0) begin bad++; $display("FAIL fill_drained got=%0b exp=0", rd_req); end
      total++; if (almost_full !== 1'b0) begin bad++; $display("FAIL fill_af_clear got=%0b exp=0", almost_full); end
   endtask

   task automatic test_back_to_back();
      int exp_v = 0;
      int drained = 0;
      for (int i = 0; i < 8; i++) drive(1'b1, 1'b1, 8'(i), 1'b0);
      for (int i = 0; i < 100; i++) begin
         total++; if (rd_data !== 8'(exp_v)) begin bad++; $display("FAIL b2b_data[%0d] got=%h exp=%h", i, rd_data, 8'(exp_v)); end
         total++; if ({rd_req, wr_ready, almost_full} !== 3'b110) begin bad++; $display("FAIL b2b_flags[%0d] got=%b exp=110", i, {rd_req, wr_ready, almost_full}); end
         drive(1'b1, 1'b1, 8'(i + 8), 1'b1);
         exp_v++;
      end
      while (rd_req === 1'b1 && drained < CAP + 1) begin
         total++; if (rd_data !== 8'(exp_v)) begin bad++; $display("FAIL b2b_drain got=%h exp=%h", rd_data, 8'(exp_v)); end
         drive(1'b1, 1'b0, 8'h00, 1'b1);
         exp_v++;
         drained++;
      end
      total++; if (drained != 8) begin bad++; $display("FAIL b2b_occupancy got=%0d exp=8", drained); end
   endtask

   task automatic test_wrap();
      for (int ph = 0; ph < 4; ph++) begin
         for (int j = 0; j < CAP; j++) begin
            if (ph % 2 == 0) begin
               drive(1'b1, 1'b1, 8'($urandom_range(0, 255)), 1'b0);
            end else begin
               total++; if (rd_data !== q[0]) begin bad++; $display("FAIL wrap_data[%0d,%0d] got=%h exp=%h", ph, j, rd_data, q[0]); end
               drive(1'b1, 1'b0, 8'h00, 1'b1);
            end
         end
         total++; if (wr_ready !== (ph % 2 == 1)) begin bad++; $display("FAIL wrap_wr_ready[%0d] got=%0b exp=%0b", ph, wr_ready, (ph % 2 == 1)); end
         total++; if (rd_req !== (ph % 2 == 0)) begin bad++; $display("FAIL wrap_rd_req[%0d] got=%0b exp=%0b", ph, rd_req, (ph % 2 == 0)); end
         total++; if (almost_full !== (ph % 2 == 0)) begin bad++; $display("FAIL wrap_af[%0d] got=%0b exp=%0b", ph, almost_full, (ph % 2 == 0)); end
      end
   endtask

   task automatic test_mid_reset();
      for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 8'(8'hA0 + i), 1'b0);
      drive(1'b0, 1'b1, 8'h77, 1'b1);
      total++; if (rd_req !== 1'b0) begin bad++; $display("FAIL mrst_rd_req got=%0b exp=0", rd_req); end
      total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL mrst_wr_ready got=%0b exp=1", wr_ready); end
      drive(1'b1, 1'b1, 8'h5A, 1'b0);
      total++; if (rd_req !== 1'b1) begin bad++; $display("FAIL mrst_first_req got=%0b exp=1", rd_req); end
      total++; if (rd_data !== 8'h5A) begin bad++; $display("FAIL mrst_first_data got=%h exp=5a", rd_data); end
      drive(1'b1, 1'b0, 8'h00, 1'b1);
      total++; if (rd_req !== 1'b0) begin bad++; $display("FAIL mrst_empty got=%0b exp=0", rd_req); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         total++; if (rd_req !== (q.size() != 0)) begin bad++; $display("FAIL rand_rd_req[%0d] got=%0b exp=%0b", i, rd_req, (q.size() != 0)); end
         total++; if (wr_ready !== (q.size() != CAP)) begin bad++; $display("FAIL rand_wr_ready[%0d] got=%0b exp=%0b", i, wr_ready, (q.size() != CAP)); end
         total++; if (almost_full !== (q.size() >= AF)) begin bad++; $display("FAIL rand_af[%0d] got=%0b exp=%0b", i, almost_full, (q.size() >= AF)); end
         if (q.size() != 0) begin
            total++; if (rd_data !== q[0]) begin bad++; $display("FAIL rand_data[%0d] got=%h exp=%h", i, rd_data, q[0]); end
         end
`ifdef UART_BYTE_FIFO_STATS_EN
         total++; if (overflow_cnt !== 8'(ovf_m)) begin bad++; $display("FAIL rand_ovf[%0d] got=%0d exp=%0d", i, overflow_cnt, ovf_m); end
`endif
         drive(($urandom_range(0, 63) != 0), ($urandom_range(0, 99) < 60), 8'($urandom_range(0, 255)),
               ($urandom_range(0, 99) < 45));
      end
   endtask

`ifdef UART_BYTE_FIFO_STATS_EN
   task automatic test_overflow();
      drive(1'b0, 1'b0, 8'h00, 1'b0);
      for (int i = 0; i < CAP; i++) drive(1'b1, 1'b1, 8'(i), 1'b0);
      for (int i = 0; i < 300; i++) drive(1'b1, 1'b1, 8'hEE, 1'b0);
      total++; if (overflow_cnt !== 8'd255) begin bad++; $display("FAIL ovf_sat got=%0d exp=255", overflow_cnt); end
      total++; if (rd_data !== 8'h00) begin bad++; $display("FAIL ovf_head got=%h exp=00", rd_data); end
      drive(1'b0, 1'b0, 8'h00, 1'b0);
      total++; if (overflow_cnt !== 8'd0) begin bad++; $display("FAIL ovf_clear got=%0d exp=0", overflow_cnt); end
   endtask
`endif

   initial begin
      reset_   = 1'b0;
      wr_req   = 1'b0;
      wr_data  = 8'h00;
      rd_ready = 1'b0;
      test_reset();
      test_show_ahead();
      test_fill();
      test_back_to_back();
      test_wrap();
      test_reset();
      test_mid_reset();
      test_random();
`ifdef UART_BYTE_FIFO_STATS_EN
      test_overflow();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
